rtc_core: RTL and testbench



---
 rtl/rtc_core_if.sv | 30 +++
 rtl/rtc_core.sv | 94 +++++++++
 tb/tb_rtc_core.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_core_if.sv
// rtc_core_if: strobes, load data and time outputs exchanged between the
// register block (master) and the RTC counter (slave).
interface rtc_core_if;
   logic        time_ld_in;
   logic [37:0] time_reg_ns_in;
   logic [47:0] time_reg_sec_in;
   logic        period_ld_in;
   logic [39:0] period_in;
   logic        adj_ld_in;
   logic [31:0] adj_ld_data_in;
   logic [39:0] period_adj_in;
   logic        adj_ld_done_out;
   logic [37:0] time_reg_ns_out;
   logic [47:0] time_reg_sec_out;
   logic        time_one_pps_out;

   modport master (
      output time_ld_in, time_reg_ns_in, time_reg_sec_in,
      output period_ld_in, period_in,
      output adj_ld_in, adj_ld_data_in, period_adj_in,
      input  adj_ld_done_out, time_reg_ns_out, time_reg_sec_out, time_one_pps_out
   );

   modport slave (
      input  time_ld_in, time_reg_ns_in, time_reg_sec_in,
      input  period_ld_in, period_in,
      input  adj_ld_in, adj_ld_data_in, period_adj_in,
      output adj_ld_done_out, time_reg_ns_out, time_reg_sec_out, time_one_pps_out
   );
endinterface

// File: rtl/rtc_core.sv
// rtc_core: 1588 real-time clock counter. ns is accumulated with 32 fractional
// bits so period trimming is exact; seconds advance on each ns rollover.
// Define RTC_ONE_PPS_EN to build the one-PPS pulse generator.
module rtc_core #(
   parameter logic [39:0] PERIOD_DEFAULT = 40'h08_0000_0000,
   parameter logic [29:0] NS_PER_SEC     = 30'd1_000_000_000,
   parameter logic [15:0] PPS_WIDTH      = 16'd12500
) (
   input logic       clk,
   input logic       rst,
   rtc_core_if.slave bus
);
   localparam logic [61:0] NS_LIMIT = {NS_PER_SEC, 32'd0};

   logic [61:0] acc_ns;
   logic [47:0] sec;
   logic [39:0] period_reg;
   logic [39:0] padj_reg;
   logic [31:0] adj_cnt;
   logic        adj_done;

   logic [39:0] step;
   logic [62:0] sum;
   logic        rollover;
   logic [61:0] acc_next;

   // Step selection and single-rollover wrap of the accumulated ns.
   always_comb begin
      step     = (adj_cnt != 32'd0) ? padj_reg : period_reg;
      sum      = {1'b0, acc_ns} + {23'd0, step};
      rollover = (sum >= {1'b0, NS_LIMIT});
      acc_next = sum[61:0];
      if (rollover) acc_next = sum[61:0] - NS_LIMIT;
   end

   // Time, period and adjustment state; a time load overrides the increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_ns     <= '0;
         sec        <= '0;
         period_reg <= PERIOD_DEFAULT;
         padj_reg   <= '0;
         adj_cnt    <= '0;
         adj_done   <= 1'b1;
      end else begin
         if (bus.time_ld_in) begin
            acc_ns <= {bus.time_reg_ns_in, 24'd0};
            sec    <= bus.time_reg_sec_in;
         end else begin
            acc_ns <= acc_next;
            if (rollover) sec <= sec + 48'd1;
         end
         if (bus.period_ld_in) period_reg <= bus.period_in;
         // A new adjustment restarts the down-counter without decrementing.
         if (bus.adj_ld_in) begin
            padj_reg <= bus.period_adj_in;
            adj_cnt  <= bus.adj_ld_data_in;
            adj_done <= (bus.adj_ld_data_in == 32'd0);
         end else if (adj_cnt != 32'd0) begin
            adj_cnt <= adj_cnt - 32'd1;
            if (adj_cnt == 32'd1) adj_done <= 1'b1;
         end
      end
   end

   assign bus.time_reg_ns_out  = acc_ns[61:24];
   assign bus.time_reg_sec_out = sec;
   assign bus.adj_ld_done_out  = adj_done;

`ifdef RTC_ONE_PPS_EN
   logic [15:0] pps_cnt;
   logic        pps;

   // PPS pulse: starts on a counted rollover, held for PPS_WIDTH clocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         pps_cnt <= '0;
         pps     <= 1'b0;
      end else if (!bus.time_ld_in && rollover) begin
         pps_cnt <= PPS_WIDTH - 16'd1;
         pps     <= 1'b1;
      end else if (pps) begin
         if (pps_cnt == 16'd0) pps <= 1'b0;
         else pps_cnt <= pps_cnt - 16'd1;
      end
   end

   assign bus.time_one_pps_out = pps;
`else
   logic unused_pps_width;
   assign unused_pps_width     = ^PPS_WIDTH;
   assign bus.time_one_pps_out = 1'b0;
`endif
endmodule

// File: tb/tb_rtc_core.sv
// tb_rtc_core: table of per-cycle stimulus records with optional hand-derived
// expectations, plus a behavioural model feeding an expected-value queue.
module tb_rtc_core;
   localparam longint NSPS = 64'd1000000000;
   localparam longint M32  = 64'hFFFF_FFFF;
   localparam longint M48  = 64'hFFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b0;
   rtc_core_if bus();

   rtc_core dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        tld;
      logic [37:0] tns;
      logic [47:0] tsec;
      logic        pld;
      logic [39:0] per;
      logic        ald;
      logic [31:0] adata;
      logic [39:0] padj;
      logic        chk;
      logic [37:0] ens;
      logic [47:0] esec;
      logic        edone;
      string       name;
   } vec_t;

   typedef struct {
      logic [37:0] ns;
      logic [47:0] sec;
      logic        done;
      logic        pps;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   longint      m_int, m_frac, m_sec, m_cnt, m_ppscnt;
   logic [39:0] m_per, m_padj;
   logic        m_done, m_pps;

   function automatic logic [37:0] nsv(input longint i, input logic [7:0] f);
      return {i[29:0], f};
   endfunction

   task automatic add(input logic r, input logic tld, input logic [37:0] tns,
                      input logic [47:0] tsec, input logic pld, input logic [39:0] per,
                      input logic ald, input logic [31:0] adata, input logic [39:0] padj,
                      input logic chk, input logic [37:0] ens, input logic [47:0] esec,
                      input logic edone, input string name);
      vec_t t;
      t.rst = r; t.tld = tld; t.tns = tns; t.tsec = tsec;
      t.pld = pld; t.per = per; t.ald = ald; t.adata = adata; t.padj = padj;
      t.chk = chk; t.ens = ens; t.esec = esec; t.edone = edone; t.name = name;
      tbl.push_back(t);
   endtask

   task automatic idle(input logic [37:0] ens, input logic [47:0] esec,
                       input logic edone, input string name);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ens, esec, edone, name);
   endtask

   task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic model_step(input vec_t t);
      logic [39:0] st;
      logic        roll;
      roll = 1'b0;
      if (t.rst) begin
         m_int = 0; m_frac = 0; m_sec = 0; m_cnt = 0;
         m_per = 40'h08_0000_0000; m_padj = '0; m_done = 1'b1;
         m_pps = 1'b0; m_ppscnt = 0;
         return;
      end
      st = (m_cnt != 0) ? m_padj : m_per;
      if (t.tld) begin
         m_int  = longint'(t.tns[37:8]);
         m_frac = longint'({t.tns[7:0], 24'd0});
         m_sec  = longint'(t.tsec);
      end else begin
         m_frac = m_frac + longint'(st[31:0]);
         m_int  = m_int + longint'(st[39:32]) + (m_frac >> 32);
         m_frac = m_frac & M32;
         if (m_int >= NSPS) begin
            m_int = m_int - NSPS;
            m_sec = (m_sec + 1) & M48;
            roll  = 1'b1;
         end
      end
      if (t.pld) m_per = t.per;
      if (t.ald) begin
         m_padj = t.padj; m_cnt = longint'(t.adata); m_done = (t.adata == 0);
      end else if (m_cnt != 0) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) m_done = 1'b1;
      end
`ifdef RTC_ONE_PPS_EN
      if (roll) begin
         m_pps = 1'b1; m_ppscnt = 12499;
      end else if (m_pps) begin
         if (m_ppscnt == 0) m_pps = 1'b0;
         else m_ppscnt = m_ppscnt - 1;
      end
`else
      m_pps = 1'b0;
      if (roll) m_ppscnt = 0;
`endif
   endtask

   task automatic apply(input vec_t t);
      exp_t e;
      @(negedge clk);
      rst                = t.rst;
      bus.time_ld_in     = t.tld;
      bus.time_reg_ns_in = t.tns;
      bus.time_reg_sec_in = t.tsec;
      bus.period_ld_in   = t.pld;
      bus.period_in      = t.per;
      bus.adj_ld_in      = t.ald;
      bus.adj_ld_data_in = t.adata;
      bus.period_adj_in  = t.padj;
      model_step(t);
      e.ns   = {m_int[29:0], m_frac[31:24]};
      e.sec  = m_sec[47:0];
      e.done = m_done;
      e.pps  = m_pps;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s/queue: got empty expected entry", t.name);
      end else begin
         e = sb.pop_front();
         check({t.name, "/ns"},   64'(bus.time_reg_ns_out),  64'(e.ns));
         check({t.name, "/sec"},  64'(bus.time_reg_sec_out), 64'(e.sec));
         check({t.name, "/done"}, 64'(bus.adj_ld_done_out),  64'(e.done));
         check({t.name, "/pps"},  64'(bus.time_one_pps_out), 64'(e.pps));
      end
      if (t.chk) begin
         check({t.name, "/ns_tbl"},   64'(bus.time_reg_ns_out),  64'(t.ens));
         check({t.name, "/sec_tbl"},  64'(bus.time_reg_sec_out), 64'(t.esec));
         check({t.name, "/done_tbl"}, 64'(bus.adj_ld_done_out),  64'(t.edone));
      end
   endtask

   initial begin
      #10ms;
      $display("FAIL timeout: got no finish expected finish before 10ms");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t t;
      int   hi;
      bus.time_ld_in = 0; bus.time_reg_ns_in = 0; bus.time_reg_sec_in = 0;
      bus.period_ld_in = 0; bus.period_in = 0; bus.adj_ld_in = 0;
      bus.adj_ld_data_in = 0; bus.period_adj_in = 0;

      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "reset");
      idle(nsv(8, 0), 0, 1, "idle1");
      idle(nsv(16, 0), 0, 1, "idle2");
      idle(nsv(24, 0), 0, 1, "idle3");
      idle(nsv(32, 0), 0, 1, "idle4");
      add(0, 1, nsv(999_999_992, 0), 5, 0, 0, 0, 0, 0, 1, nsv(999_999_992, 0), 5, 1, "tld_roll");
      idle(nsv(0, 0), 6, 1, "rollover");
      add(0, 1, 0, 0, 1, 40'h08_8000_0000, 0, 0, 0, 1, 0, 0, 1, "pld_8p5");
      idle(nsv(8, 8'h80), 0, 1, "p8p5_1");
      idle(nsv(17, 0), 0, 1, "p8p5_2");
      add(0, 1, 0, 0, 1, 40'h08_0000_0000, 0, 0, 0, 1, 0, 0, 1, "pld_8");
      add(0, 1, 0, 0, 0, 0, 1, 4, 40'h09_0000_0000, 1, 0, 0, 0, "adj4_ld");
      idle(nsv(9, 0), 0, 0, "adj4_1");
      idle(nsv(18, 0), 0, 0, "adj4_2");
      idle(nsv(27, 0), 0, 0, "adj4_3");
      idle(nsv(36, 0), 0, 1, "adj4_4");
      idle(nsv(44, 0), 0, 1, "adj4_5");
      add(0, 0, 0, 0, 0, 0, 1, 0, 40'h09_0000_0000, 1, nsv(52, 0), 0, 1, "adj0_ld");
      idle(nsv(60, 0), 0, 1, "adj0_1");
      add(0, 1, 0, 0, 0, 0, 1, 10, 40'h09_0000_0000, 1, 0, 0, 0, "adj10_ld");
      idle(nsv(9, 0), 0, 0, "adj10_1");
      idle(nsv(18, 0), 0, 0, "adj10_2");
      add(0, 0, 0, 0, 0, 0, 1, 2, 40'h09_0000_0000, 1, nsv(27, 0), 0, 0, "adj2_restart");
      idle(nsv(36, 0), 0, 0, "adjr_4");
      idle(nsv(45, 0), 0, 1, "adjr_5");
      idle(nsv(53, 0), 0, 1, "adjr_after");
      add(0, 1, nsv(999_999_996, 0), 7, 0, 0, 0, 0, 0, 1, nsv(999_999_996, 0), 7, 1, "tld_996");
      add(0, 1, nsv(100, 0), 7, 0, 0, 0, 0, 0, 1, nsv(100, 0), 7, 1, "tld_wins");
      idle(nsv(108, 0), 7, 1, "tld_wins_1");
      add(0, 0, 0, 0, 0, 0, 1, 100, 40'h09_0000_0000, 1, nsv(116, 0), 7, 0, "adj100_ld");
      idle(nsv(125, 0), 7, 0, "adj100_1");
      add(1, 1, nsv(5, 0), 9, 0, 0, 1, 3, 40'h01_0000_0000, 1, 0, 0, 1, "rst_mid_adj");
      idle(nsv(8, 0), 0, 1, "post_rst1");
      idle(nsv(16, 0), 0, 1, "post_rst2");
      add(0, 1, nsv(1073741800, 0), 48'hFFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 1,
          nsv(1073741800, 0), 48'hFFFF_FFFF_FFFF, 1, "tld_big");
      idle(nsv(73741808, 0), 0, 1, "big_roll");
      add(0, 0, 0, 0, 1, 40'h00_4000_0000, 0, 0, 0, 1, nsv(73741816, 0), 0, 1, "pld_q");
      idle(nsv(73741816, 8'h40), 0, 1, "frac_q");
      add(0, 0, 0, 0, 1, 40'h00_C000_0001, 0, 0, 0, 1, nsv(73741816, 8'h80), 0, 1, "pld_3q");
      idle(nsv(73741817, 8'h40), 0, 1, "frac_carry1");
      idle(nsv(73741818, 8'h00), 0, 1, "frac_carry2");
      add(0, 0, 0, 0, 1, 40'h08_0000_0000, 0, 0, 0, 1, nsv(73741818, 8'hC0), 0, 1, "pld_back");
      idle(nsv(73741826, 8'hC0), 0, 1, "frac_keep");

      foreach (tbl[i]) apply(tbl[i]);

      for (int k = 0; k < 400; k++) begin
         t.rst   = ($urandom_range(0, 63) == 0);
         t.tld   = ($urandom_range(0, 15) == 0);
         t.tns   = {($urandom_range(0, 1) == 1) ? 30'($urandom_range(999_999_700, 1_000_000_050))
                                                 : 30'($urandom_range(0, 1073741823)),
                    8'($urandom_range(0, 255))};
         t.tsec  = {16'($urandom), 32'($urandom)};
         t.pld   = ($urandom_range(0, 15) == 0);
         t.per   = {8'($urandom_range(0, 255)), 32'($urandom)};
         t.ald   = ($urandom_range(0, 15) == 0);
         t.adata = 32'($urandom_range(0, 12));
         t.padj  = {8'($urandom_range(0, 255)), 32'($urandom)};
         t.chk   = 0; t.ens = 0; t.esec = 0; t.edone = 0;
         t.name  = "rnd";
         apply(t);
      end

`ifdef RTC_ONE_PPS_EN
      t.rst = 0; t.tld = 1; t.tns = nsv(999_999_992, 0); t.tsec = 0;
      t.pld = 1; t.per = 40'h08_0000_0000; t.ald = 1; t.adata = 0; t.padj = 0;
      t.chk = 0; t.ens = 0; t.esec = 0; t.edone = 0; t.name = "pps_ld";
      apply(t);
      t.tld = 0; t.pld = 0; t.ald = 0; t.name = "pps_run";
      hi = 0;
      for (int k = 0; k < 12510; k++) begin
         apply(t);
         if (bus.time_one_pps_out) hi++;
      end
      check("pps_width", 64'(hi), 64'd12500);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
